fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the pipelined MIPS core. Owns the program counter and drives the instruction memory address.
- Captures the returned instruction into the IF/ID pipeline register for decode.
- Handles stall, flush and branch/jump redirects from later stages, plus end-of-program halt detection.
- Sits directly upstream of the instruction memory (pc) and consumes its instruction output.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- IMEM_DEPTH, 64, instruction memory depth in words; byte limit = IMEM_DEPTH*4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- pc_o  output  32  byte address to instruction memory pc input
- instr_i  input  32  instruction returned combinationally for pc_o
- stall_i  input  1  hazard stall: hold PC and IF/ID
- flush_i  input  1  squash IF/ID contents (bubble)
- redirect_i  input  1  taken branch/jump
- redirect_pc_i  input  32  redirect target byte address
- if_id_instr_o  output  32  IF/ID instruction
- if_id_pc4_o  output  32  IF/ID PC+4
- if_id_valid_o  output  1  IF/ID holds a real instruction
- halted_o  output  1  fetch stopped, PC out of range
- misalign_o  output  1  sticky: a redirect target had bits[1:0] != 0

Behaviour:
- Reset (rst=0, async): pc_o=RESET_PC, state=BOOT, if_id_instr_o=0, if_id_pc4_o=0, if_id_valid_o=0, halted_o=0, misalign_o=0.
- BOOT: lasts exactly one clock after reset release. No IF/ID capture and PC held, so the memory image settles. Then goes to RUN, regardless of inputs.
- RUN, per clock edge, priority redirect > flush > stall > normal:
  - redirect_i=1: pc <= {redirect_pc_i[31:2],2'b00}. IF/ID <= bubble (instr 0, pc4 0, valid 0). If redirect_pc_i[1:0]!=0, misalign_o <= 1. This applies even when stall_i=1.
  - flush_i=1 (no redirect): IF/ID <= bubble. If stall_i=1, PC holds; otherwise pc <= pc+4.
  - stall_i=1 only: PC and IF/ID both hold all values.
  - Normal: IF/ID <= {instr_i, pc+4, valid 1}; pc <= pc+4.
- Halt check:
  - In RUN, if pc_o >= IMEM_DEPTH*4 at the edge and redirect_i=0: state <= HALT, halted_o <= 1, IF/ID <= bubble, PC holds.
  - This check overrides stall and flush.
- HALT: PC held and IF/ID bubble every cycle; stall_i and flush_i are ignored.
  - redirect_i=1 with target < IMEM_DEPTH*4: pc <= aligned target, state <= RUN, halted_o <= 0.
  - Out-of-range redirect: PC loads the target and the block stays in HALT.
- Arithmetic: PC+4 is 32-bit modulo. Wrap cannot occur in practice because halt triggers first.
- Latency: instruction at pc_o appears on IF/ID outputs one edge later.
- Reset asserted mid-operation: all state returns to reset values immediately. BOOT repeats after release.
- misalign_o clears only on reset.

Decomposition:
- Shared package (core pipeline package):
  - fetch state enum {BOOT, RUN, HALT}
  - NOP_INSTR = 32'h0
  - WORD_BYTES = 4
  - RESET_PC default
- One sub-module: if_id_reg. Holds the instruction, PC+4 and valid registers, with hold, bubble and load controls.
- Top-level contents: the PC register, the FSM and priority logic.

Test Plan:
- Reset, release, stream: cycle 1 valid=0 (BOOT). Then IF/ID pc4 = 4, 8, 12 with the matching instructions, valid=1.
- stall_i=1 for 2 cycles at pc_o=0x14: pc_o stays 0x14 and IF/ID is unchanged. On release, IF/ID pc4=0x18.
- redirect_i=1, redirect_pc_i=0x30 together with stall_i=1: next cycle pc_o=0x30, valid=0. Next cycle pc4=0x34, valid=1.
- redirect_pc_i=0x23: pc_o=0x20 and misalign_o=1. misalign_o stays 1 through later redirects until reset.
- Run to pc_o=0x100 (IMEM_DEPTH=64): halted_o=1, valid=0, pc_o holds. Redirect to 0x8 gives halted_o=0 and fetch resumes (pc4=0xC).
- Assert rst low mid-stream at pc_o=0x40: all outputs zero and pc_o=0 immediately. The BOOT bubble is seen after release.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the IF stage: fetch states, the NOP encoding
// and the word-alignment helper.
package fetch_stage_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
   localparam int          WORD_BYTES   = 4;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid.
// Bubble clears to a NOP, hold keeps the contents, load captures new ones.
module fetch_stage_if_id_reg
   import fetch_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        bubble_i,
   input  logic        hold_i,
   input  logic        load_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc4_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc4_o,
   output logic        valid_o
);

   logic [31:0] instr_d, instr_q;
   logic [31:0] pc4_d,   pc4_q;
   logic        valid_d, valid_q;

   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (bubble_i) begin
         instr_d = NOP_INSTR;
         pc4_d   = 32'h0;
         valid_d = 1'b0;
      end else if (!hold_i && load_i) begin
         instr_d = instr_i;
         pc4_d   = pc4_i;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instr_q <= NOP_INSTR;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign instr_o = instr_q;
   assign pc4_o   = pc4_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: program counter, BOOT/RUN/HALT sequencing and the
// redirect > halt > flush > stall > normal priority feeding the IF/ID register.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter int          IMEM_DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] pc_o,
   input  logic [31:0] instr_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] if_id_instr_o,
   output logic [31:0] if_id_pc4_o,
   output logic        if_id_valid_o,
   output logic        halted_o,
   output logic        misalign_o
);

   localparam logic [31:0] PC_LIMIT = 32'(IMEM_DEPTH * WORD_BYTES);

   fetch_state_e state_d, state_q;
   logic [31:0]  pc_d, pc_q;
   logic         halted_d, halted_q;
   logic         misalign_d, misalign_q;
   logic         ifid_bubble, ifid_hold, ifid_load;
   logic [31:0]  pc_plus4;

   assign pc_plus4 = pc_q + 32'(WORD_BYTES);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      halted_d    = halted_q;
      misalign_d  = misalign_q;
      ifid_bubble = 1'b0;
      ifid_hold   = 1'b1;
      ifid_load   = 1'b0;
      unique case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (redirect_i) begin
               pc_d        = align_word(redirect_pc_i);
               ifid_bubble = 1'b1;
               if (redirect_pc_i[1:0] != 2'b00) misalign_d = 1'b1;
            end else if (pc_q >= PC_LIMIT) begin
               // Out-of-range PC beats stall/flush so fetch stops cleanly.
               state_d     = ST_HALT;
               halted_d    = 1'b1;
               ifid_bubble = 1'b1;
            end else if (flush_i) begin
               ifid_bubble = 1'b1;
               if (!stall_i) pc_d = pc_plus4;
            end else if (!stall_i) begin
               ifid_hold = 1'b0;
               ifid_load = 1'b1;
               pc_d      = pc_plus4;
            end
         end
         ST_HALT: begin
            ifid_bubble = 1'b1;
            if (redirect_i) begin
               pc_d = align_word(redirect_pc_i);
               if (redirect_pc_i[1:0] != 2'b00) misalign_d = 1'b1;
               if (redirect_pc_i < PC_LIMIT) begin
                  state_d  = ST_RUN;
                  halted_d = 1'b0;
               end
            end
         end
         default: state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_PC;
         halted_q   <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         halted_q   <= halted_d;
         misalign_q <= misalign_d;
      end
   end

   fetch_stage_if_id_reg u_if_id (
      .clk      (clk),
      .rst      (rst),
      .bubble_i (ifid_bubble),
      .hold_i   (ifid_hold),
      .load_i   (ifid_load),
      .instr_i  (instr_i),
      .pc4_i    (pc_plus4),
      .instr_o  (if_id_instr_o),
      .pc4_o    (if_id_pc4_o),
      .valid_o  (if_id_valid_o)
   );

   assign pc_o       = pc_q;
   assign halted_o   = halted_q;
   assign misalign_o = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a spec-level fetch model checked every cycle,
// plus literal expectations from the test plan.
module tb_fetch_stage;

   localparam logic [31:0] LIMIT = 32'd256;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pc_o;
   logic [31:0] instr_i;
   logic        stall_i = 1'b0, flush_i = 1'b0, redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'h0;
   logic [31:0] if_id_instr_o, if_id_pc4_o;
   logic        if_id_valid_o, halted_o, misalign_o;

   int errors = 0;
   int checks = 0;

   // Model state: 0 = boot cycle pending, 1 = fetching, 2 = halted
   int          m_mode;
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid, m_halt, m_mis;

   fetch_stage #(.RESET_PC(32'h0), .IMEM_DEPTH(64)) dut (
      .clk(clk), .rst(rst), .pc_o(pc_o), .instr_i(instr_i),
      .stall_i(stall_i), .flush_i(flush_i), .redirect_i(redirect_i),
      .redirect_pc_i(redirect_pc_i), .if_id_instr_o(if_id_instr_o),
      .if_id_pc4_o(if_id_pc4_o), .if_id_valid_o(if_id_valid_o),
      .halted_o(halted_o), .misalign_o(misalign_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a < LIMIT) return 32'h8C00_0000 | (a * 32'h0001_0001);
      return 32'h0;
   endfunction

   always_comb instr_i = mem_word(pc_o);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
      m_valid = 1'b0; m_halt = 1'b0; m_mis = 1'b0;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".pc"},     pc_o,          m_pc);
      chk({tag, ".instr"},  if_id_instr_o, m_instr);
      chk({tag, ".pc4"},    if_id_pc4_o,   m_pc4);
      chk({tag, ".valid"},  {31'b0, if_id_valid_o}, {31'b0, m_valid});
      chk({tag, ".halted"}, {31'b0, halted_o},      {31'b0, m_halt});
      chk({tag, ".misal"},  {31'b0, misalign_o},    {31'b0, m_mis});
   endtask

   task automatic bubble_model();
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
   endtask

   // One clock: advance the model from the current inputs, then compare.
   task automatic step(input string tag);
      if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (redirect_i) begin
            if (redirect_pc_i % 4 != 0) m_mis = 1'b1;
            m_pc = redirect_pc_i - (redirect_pc_i % 4);
            bubble_model();
         end else if (m_pc >= LIMIT) begin
            m_mode = 2; m_halt = 1'b1;
            bubble_model();
         end else if (flush_i) begin
            bubble_model();
            if (!stall_i) m_pc = m_pc + 4;
         end else if (!stall_i) begin
            m_instr = mem_word(m_pc);
            m_pc4   = m_pc + 4;
            m_valid = 1'b1;
            m_pc    = m_pc + 4;
         end
      end else begin
         bubble_model();
         if (redirect_i) begin
            if (redirect_pc_i % 4 != 0) m_mis = 1'b1;
            m_pc = redirect_pc_i - (redirect_pc_i % 4);
            if (redirect_pc_i < LIMIT) begin
               m_mode = 1; m_halt = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   task automatic drive(input logic st, input logic fl, input logic rd, input logic [31:0] rpc);
      stall_i = st; flush_i = fl; redirect_i = rd; redirect_pc_i = rpc;
   endtask

   initial begin
      model_reset();
      #3;
      check_model("reset");
      chk("reset.pc_lit", pc_o, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      drive(0, 0, 0, 0);
      step("boot");
      chk("boot.valid_lit", {31'b0, if_id_valid_o}, 32'h0);
      step("s1"); chk("s1.pc4_lit", if_id_pc4_o, 32'h4);
      chk("s1.instr_lit", if_id_instr_o, 32'h8C00_0000);
      step("s2"); chk("s2.pc4_lit", if_id_pc4_o, 32'h8);
      step("s3"); chk("s3.pc4_lit", if_id_pc4_o, 32'hC);
      chk("s3.instr_lit", if_id_instr_o, 32'h8C08_0008);
      step("s4"); step("s5");
      chk("pre_stall.pc_lit", pc_o, 32'h14);

      drive(1, 0, 0, 0);
      step("stall1"); step("stall2");
      chk("stall.pc_lit", pc_o, 32'h14);
      chk("stall.pc4_lit", if_id_pc4_o, 32'h14);
      drive(0, 0, 0, 0);
      step("unstall"); chk("unstall.pc4_lit", if_id_pc4_o, 32'h18);

      drive(1, 0, 1, 32'h30);
      step("redir_stall");
      chk("redir.pc_lit", pc_o, 32'h30);
      drive(0, 0, 0, 0);
      step("after_redir"); chk("after_redir.pc4_lit", if_id_pc4_o, 32'h34);

      drive(0, 0, 1, 32'h23);
      step("misal");
      chk("misal.pc_lit", pc_o, 32'h20);
      chk("misal.flag_lit", {31'b0, misalign_o}, 32'h1);
      drive(0, 0, 0, 0);  step("n1");
      drive(0, 0, 1, 32'h10); step("redir_al");
      chk("sticky.flag_lit", {31'b0, misalign_o}, 32'h1);
      drive(0, 1, 0, 0);  step("flush");
      drive(1, 1, 0, 0);  step("flush_stall");
      drive(0, 0, 0, 0);  step("n2");

      for (int i = 0; i < 100 && pc_o < LIMIT; i++) step("run");
      chk("run.reached_limit", pc_o, 32'h100);
      step("halt");
      chk("halt.flag_lit", {31'b0, halted_o}, 32'h1);
      chk("halt.pc_lit", pc_o, 32'h100);
      drive(1, 1, 0, 0);  step("halt_ign");
      drive(0, 0, 1, 32'h8); step("resume");
      chk("resume.halted_lit", {31'b0, halted_o}, 32'h0);
      drive(0, 0, 0, 0);  step("resume_f");
      chk("resume.pc4_lit", if_id_pc4_o, 32'hC);

      drive(0, 0, 1, 32'h200); step("far");
      drive(0, 0, 0, 0);  step("far_halt");
      drive(0, 0, 1, 32'h300); step("halt_far");
      chk("halt_far.pc_lit", pc_o, 32'h300);
      chk("halt_far.halted_lit", {31'b0, halted_o}, 32'h1);
      drive(0, 0, 1, 32'h38); step("back");
      drive(0, 0, 0, 0);
      step("b1"); step("b2");
      chk("pre_rst.pc_lit", pc_o, 32'h40);

      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_model("midrst");
      chk("midrst.pc_lit", pc_o, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      step("boot2");
      chk("boot2.valid_lit", {31'b0, if_id_valid_o}, 32'h0);
      step("r1"); chk("r1.pc4_lit", if_id_pc4_o, 32'h4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
